pwl_antilog: RTL
================

PWL_ANTILOG -- requirements
Module: pwl_antilog

Interface
REQ-001 The block SHALL have the parameter NSEG, default 7, the number of piecewise-linear segments; NSEG-1 breakpoints.
REQ-002 The block SHALL have the parameter W, default 32, the data and coefficient width.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: an operand is offered.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: an operand can be accepted.
REQ-007 The block SHALL have the port x, input, W bits, signed: the log-domain operand.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: the result is held.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have the port out, output, 2W bits, signed: a*x+b.
REQ-011 The block SHALL have the port seg, output, 3 bits: the segment index used for out.
REQ-012 The block SHALL have the port cfg_we, input, 1 bit: a table write strobe.
REQ-013 The block SHALL have the port cfg_sel, input, 2 bits: the table select, 0=a, 1=b, 2=breakpoint, 3=reserved.
REQ-014 The block SHALL have the port cfg_addr, input, 3 bits: the table entry.
REQ-015 The block SHALL have the port cfg_data, input, W bits: the write data.
REQ-016 The block SHALL have the port cfg_busy, output, 1 bit: configuration writes are currently ignored.

Function
REQ-017 The block SHALL hold internal register tables a[0..NSEG-1], b[0..NSEG-1] and bp[1..NSEG-1], all signed W bits.
REQ-018 The block SHALL implement the state machine IDLE -> SEARCH -> FETCH -> CALC -> HOLD -> IDLE.
REQ-019 The block SHALL drive in_ready=1 only in IDLE; an operand is accepted when in_valid and in_ready are both 1 at a clk edge, x is registered, and the next state is SEARCH.
REQ-020 In SEARCH, the block SHALL set the segment index s to the count of i in 1..NSEG-1 with x >= bp[i] (signed compare), giving s = 0..NSEG-1; non-monotonic breakpoints still yield this count.
REQ-021 In FETCH, the block SHALL register a[s] and b[s] into coefficient registers.
REQ-022 In CALC, the block SHALL compute out = a[s]*x + sign-extended b[s], signed, 2W bits, wrapping modulo 2^(2W); it SHALL register out and seg=s and go to HOLD.
REQ-023 In HOLD, the block SHALL assert out_valid=1 and keep out and seg stable; when out_ready=1 it SHALL go to IDLE with out_valid=0 on the next cycle.
REQ-024 Latency SHALL be 4 cycles, from the accept edge to the first cycle with out_valid=1; throughput SHALL be one result per 5 cycles with out_ready tied to 1.
REQ-025 The block SHALL apply cfg_we only in IDLE with cfg_sel != 3; cfg_busy=1 in every other state, and the write is then dropped.
REQ-026 The block SHALL ignore writes with cfg_sel=2 and cfg_addr=0, and writes with cfg_addr >= NSEG.
REQ-027 On a simultaneous cfg_we and accept in IDLE, the table write SHALL complete first, and SEARCH SHALL see the new value.
REQ-028 out SHALL retain its last value after HOLD exits; only out_valid qualifies it.

Reset
REQ-029 With rst_n=0, the block SHALL immediately (asynchronously) force: state=IDLE, in_ready=1, out_valid=0, out=0, seg=0, cfg_busy=0, and all a/b/bp entries=0.
REQ-030 Reset asserted mid-transaction SHALL discard that transaction; no out_valid pulse is allowed after rst_n returns high.
REQ-031 After reset, the zero tables SHALL give out=0 for any x.

Configuration
REQ-032 With the macro PWL_ANTILOG_SAT_EN defined, CALC SHALL clamp the 2W-bit sum to the signed W-bit range [-2^(W-1), 2^(W-1)-1] before registering it, sign-extended onto out.
REQ-033 With PWL_ANTILOG_SAT_EN undefined, out SHALL be the unclamped wrapped 2W-bit sum, and no clamp logic SHALL exist.

Verification
REQ-034 Test: reset, then x=5 -> out=0, seg=0, out_valid=1 exactly 4 cycles after accept.
REQ-035 Test: bp={-100,0,100,200,300,400}, a[3]=3, b[3]=7, x=150 -> seg=3, out=457.
REQ-036 Test: same tables, x=-101 -> seg=0; x=400 -> seg=6; x=399 -> seg=5.
REQ-037 Test: out_ready held 0 for 10 cycles in HOLD -> out stable and in_ready=0 throughout; a cfg_we pulse during this time is dropped, readback via the next result is unchanged.
REQ-038 Test: a[6]=0x7FFFFFFF, b[6]=0, x=0x7FFFFFFF, bp all <=x -> out=0x3FFFFFFF00000001 without SAT_EN; with SAT_EN, out=0x000000007FFFFFFF.
REQ-039 Test: rst_n pulsed low during FETCH -> out_valid stays 0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/pwl_antilog.sv
// Piecewise-linear antilog evaluator: out = a[s]*x + b[s], s chosen by breakpoint count.
// Optional output clamp to the signed W-bit range when PWL_ANTILOG_SAT_EN is defined.
module pwl_antilog #(
    parameter int NSEG = 7,
    parameter int W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*W-1:0] out,
    output logic [2:0]            seg,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [2:0]            cfg_addr,
    input  logic [W-1:0]          cfg_data,
    output logic                  cfg_busy
);

    typedef enum logic [2:0] {IDLE, SEARCH, FETCH, CALC, HOLD} state_t;

    state_t                state_q;
    logic signed [W-1:0]   x_q, ca_q, cb_q;
    logic signed [W-1:0]   a_tab_q  [NSEG];
    logic signed [W-1:0]   b_tab_q  [NSEG];
    logic signed [W-1:0]   bp_tab_q [1:NSEG-1];
    logic [2:0]            s_q, seg_q, cnt_d;
    logic                  in_ready_q, out_valid_q, cfg_busy_q;
    logic signed [2*W-1:0] out_q, ca_x, x_x, cb_x, sum_d, res_d;
    logic                  cfg_ok_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign seg       = seg_q;
    assign cfg_busy  = cfg_busy_q;

    // Breakpoints need not be monotonic: the segment is simply how many are <= x.
    always_comb begin
        cnt_d = 3'd0;
        for (int i = 1; i < NSEG; i++)
            if (x_q >= bp_tab_q[i]) cnt_d = cnt_d + 3'd1;
    end

    assign ca_x  = {{W{ca_q[W-1]}}, ca_q};
    assign x_x   = {{W{x_q[W-1]}}, x_q};
    assign cb_x  = {{W{cb_q[W-1]}}, cb_q};
    assign sum_d = ca_x * x_x + cb_x;

`ifdef PWL_ANTILOG_SAT_EN
    // Fits in W signed bits only when the top W+1 bits all match the sign.
    always_comb begin
        res_d = sum_d;
        if (!sum_d[2*W-1] && (|sum_d[2*W-2:W-1]))
            res_d = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        else if (sum_d[2*W-1] && !(&sum_d[2*W-2:W-1]))
            res_d = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    end
`else
    assign res_d = sum_d;
`endif

    assign cfg_ok_d = cfg_we && (state_q == IDLE) && (cfg_sel != 2'd3) &&
                      !((cfg_sel == 2'd2) && (cfg_addr == 3'd0));

    // Table writes land on the accept edge too, so SEARCH already sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                a_tab_q[i] <= '0;
                b_tab_q[i] <= '0;
            end
            for (int i = 1; i < NSEG; i++) bp_tab_q[i] <= '0;
        end else if (cfg_ok_d) begin
            for (int i = 0; i < NSEG; i++) begin
                if (int'(cfg_addr) == i) begin
                    if (cfg_sel == 2'd0) a_tab_q[i] <= cfg_data;
                    if (cfg_sel == 2'd1) b_tab_q[i] <= cfg_data;
                end
            end
            for (int i = 1; i < NSEG; i++)
                if ((cfg_sel == 2'd2) && (int'(cfg_addr) == i)) bp_tab_q[i] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cfg_busy_q  <= 1'b0;
            x_q         <= '0;
            s_q         <= '0;
            ca_q        <= '0;
            cb_q        <= '0;
            out_q       <= '0;
            seg_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    x_q        <= x;
                    state_q    <= SEARCH;
                    in_ready_q <= 1'b0;
                    cfg_busy_q <= 1'b1;
                end
                SEARCH: begin
                    s_q     <= cnt_d;
                    state_q <= FETCH;
                end
                FETCH: begin
                    for (int i = 0; i < NSEG; i++) begin
                        if (int'(s_q) == i) begin
                            ca_q <= a_tab_q[i];
                            cb_q <= b_tab_q[i];
                        end
                    end
                    state_q <= CALC;
                end
                CALC: begin
                    out_q       <= res_d;
                    seg_q       <= s_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    cfg_busy_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    cfg_busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
